// File: rtl/mp_pkg.sv
// ---------------------------------------------------------------------------
// mp_pkg
// Shared types for the multi-precision carry-save accumulator:
//   mp_op_e      operation encoding on the op port
//   mp_state_e   accumulator FSM states
//   mp_ceil_div  ceiling division used to size the resolve chunk count
// ---------------------------------------------------------------------------
package mp_pkg;

  typedef enum logic [1:0] {
    MP_ADD       = 2'b00,
    MP_SUB       = 2'b01,
    MP_ADD_SHIFT = 2'b10,
    MP_CLEAR     = 2'b11
  } mp_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RESOLVE = 2'b01,
    ST_DONE    = 2'b10
  } mp_state_e;

  function automatic int mp_ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/mp_csa_row.sv
// ---------------------------------------------------------------------------
// mp_csa_row
// Combinational W-bit 3:2 compressor. The carry output is already shifted
// left by one (bit 0 is zero, the top majority bit is dropped).
// Ports:
//   i_a, i_b, i_c  [W-1:0]  addends
//   o_sum          [W-1:0]  bitwise sum  a ^ b ^ c
//   o_carry        [W-1:0]  maj(a,b,c) << 1
// ---------------------------------------------------------------------------
module mp_csa_row #(
  parameter int W = 516
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = ((i_a & i_b) | (i_a & i_c) | (i_b & i_c)) << 1;

endmodule

// File: rtl/mp_csa_accumulator.sv
// ---------------------------------------------------------------------------
// mp_csa_accumulator
// Multi-precision accumulator holding its value in carry-save form
// (V = S + C + cin mod 2^ACC_W). One ADD / SUB / ADD_SHIFT / CLEAR per cycle
// in IDLE; on resolve_start the redundant value is collapsed in place with a
// CHUNK-bit ripple adder, one chunk per cycle, followed by a done pulse.
//
// Optional build macro MP_RESULT_WINDOW_EN: the result port narrows to CHUNK
// bits and selects S[win_sel*CHUNK +: CHUNK] (registered) via i_win_sel.
//
// Ports:
//   i_clk            clock, rising edge
//   i_reset          asynchronous active-high reset
//   i_op_valid       apply i_op this cycle (only honoured in IDLE)
//   i_op [1:0]       00 ADD, 01 SUB, 10 ADD_SHIFT, 11 CLEAR
//   i_operand        unsigned WIDTH-bit operand
//   o_op_ready       high in IDLE
//   i_resolve_start  request carry resolution
//   o_done           one-cycle pulse, result valid
//   o_result         S[WIDTH:0] after resolution (window mode: CHUNK-bit slice)
//   o_carry_zero     registered flag: carry register and cin both zero
//   i_win_sel        window select (window mode only)
// ---------------------------------------------------------------------------
module mp_csa_accumulator
  import mp_pkg::*;
#(
  parameter int WIDTH = 514,
  parameter int CHUNK = 128
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_op_valid,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_operand,
  output logic             o_op_ready,
  input  logic             i_resolve_start,
  output logic             o_done,
`ifdef MP_RESULT_WINDOW_EN
  input  logic [$clog2(mp_ceil_div(WIDTH+2, CHUNK))-1:0] i_win_sel,
  output logic [CHUNK-1:0] o_result,
`else
  output logic [WIDTH:0]   o_result,
`endif
  output logic             o_carry_zero
);

  localparam int ACC_W  = WIDTH + 2;
  localparam int NCHUNK = mp_ceil_div(ACC_W, CHUNK);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  mp_state_e        r_state, w_state_nxt;
  logic             r_pending, w_pending_nxt;
  logic [KW-1:0]    r_k, w_k_nxt;
  logic [ACC_W-1:0] r_s, w_s_nxt;
  logic [ACC_W-1:0] r_c, w_c_nxt;
  logic             r_cin, w_cin_nxt;
  logic             r_cy, w_cy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_cz;
`ifdef MP_RESULT_WINDOW_EN
  logic [CHUNK-1:0] r_result;
`else
  logic [WIDTH:0]   r_result;
`endif

  logic [ACC_W-1:0] w_a, w_csa_s, w_csa_c, w_mask;
  logic [CHUNK-1:0] w_s_ch, w_c_ch;
  logic [CHUNK:0]   w_chunk_sum;
  logic             w_cy_in;
  int               w_base;

  // SUB adds ~operand here and the missing +1 goes into the empty carry LSB.
  assign w_a = (i_op == MP_SUB) ? ~ACC_W'(i_operand) : ACC_W'(i_operand);

  mp_csa_row #(.W(ACC_W)) u_row (
    .i_a     (r_s),
    .i_b     (r_c),
    .i_c     (w_a),
    .o_sum   (w_csa_s),
    .o_carry (w_csa_c)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
      r_k       <= '0;
      r_s       <= '0;
      r_c       <= '0;
      r_cin     <= 1'b0;
      r_cy      <= 1'b0;
      r_done    <= 1'b0;
      r_cz      <= 1'b1;
      r_result  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_k       <= w_k_nxt;
      r_s       <= w_s_nxt;
      r_c       <= w_c_nxt;
      r_cin     <= w_cin_nxt;
      r_cy      <= w_cy_nxt;
      r_done    <= w_done_nxt;
      r_cz      <= (w_c_nxt == '0) && !w_cin_nxt;
`ifdef MP_RESULT_WINDOW_EN
      r_result  <= (int'(i_win_sel) < NCHUNK) ? CHUNK'(r_s >> (int'(i_win_sel) * CHUNK)) : '0;
`else
      if (w_done_nxt) r_result <= r_s[WIDTH:0];
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_k_nxt       = r_k;
    w_s_nxt       = r_s;
    w_c_nxt       = r_c;
    w_cin_nxt     = r_cin;
    w_cy_nxt      = r_cy;
    w_done_nxt    = 1'b0;

    // Current resolve chunk; bits beyond ACC_W in the last chunk fall off the shifts.
    w_base      = int'(r_k) * CHUNK;
    w_cy_in     = (r_k == '0) ? r_cin : r_cy;
    w_s_ch      = CHUNK'(r_s >> w_base);
    w_c_ch      = CHUNK'(r_c >> w_base);
    w_chunk_sum = {1'b0, w_s_ch} + {1'b0, w_c_ch} + (CHUNK+1)'(w_cy_in);
    w_mask      = ACC_W'({CHUNK{1'b1}}) << w_base;

    case (r_state)
      ST_IDLE: begin
        if (i_op_valid) begin
          case (mp_op_e'(i_op))
            MP_ADD: begin
              w_s_nxt = w_csa_s;
              w_c_nxt = w_csa_c;
            end
            MP_SUB: begin
              w_s_nxt = w_csa_s;
              w_c_nxt = w_csa_c | ACC_W'(1);
            end
            MP_ADD_SHIFT: begin
              // The two dropped LSBs plus cin carry into the halved value.
              w_s_nxt   = w_csa_s >> 1;
              w_c_nxt   = w_csa_c >> 1;
              w_cin_nxt = (w_csa_s[0] & w_csa_c[0]) | ((w_csa_s[0] ^ w_csa_c[0]) & r_cin);
            end
            default: begin
              w_s_nxt   = '0;
              w_c_nxt   = '0;
              w_cin_nxt = 1'b0;
            end
          endcase
        end
        if (i_op_valid && i_resolve_start) begin
          w_pending_nxt = 1'b1;
        end else if (i_resolve_start || r_pending) begin
          w_state_nxt   = ST_RESOLVE;
          w_pending_nxt = 1'b0;
          w_k_nxt       = '0;
        end
      end
      ST_RESOLVE: begin
        w_s_nxt  = (r_s & ~w_mask) | (ACC_W'(w_chunk_sum[CHUNK-1:0]) << w_base);
        w_c_nxt  = r_c & ~w_mask;
        w_cy_nxt = w_chunk_sum[CHUNK];
        if (r_k == '0) w_cin_nxt = 1'b0;
        if (r_k == KW'(NCHUNK - 1)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_k_nxt = r_k + KW'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_op_ready   = (r_state == ST_IDLE);
  assign o_done       = r_done;
  assign o_result     = r_result;
  assign o_carry_zero = r_cz;

endmodule

// File: tb/tb_mp_csa_accumulator.sv
module tb_mp_csa_accumulator;

  localparam int WIDTH  = 514;
  localparam int CHUNK  = 128;
  localparam int ACC_W  = WIDTH + 2;
  localparam int NCHUNK = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             op_valid;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] operand;
  logic             op_ready;
  logic             resolve_start;
  logic             done;
  logic [WIDTH:0]   result;
  logic             carry_zero;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH:0]   sb[$];
  logic [ACC_W-1:0] m_v;

  mp_csa_accumulator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_op_valid      (op_valid),
    .i_op            (op_i),
    .i_operand       (operand),
    .o_op_ready      (op_ready),
    .i_resolve_start (resolve_start),
    .o_done          (done),
    .o_result        (result),
    .o_carry_zero    (carry_zero)
  );

  always #5 clk = ~clk;

  // Drive one op across a rising edge and update the reference value.
  task automatic do_op(input logic [1:0] op, input logic [WIDTH-1:0] val);
    logic [ACC_W:0] tmp;
    @(negedge clk);
    op_valid = 1'b1; op_i = op; operand = val;
    @(negedge clk);
    op_valid = 1'b0;
    case (op)
      2'b00: m_v = m_v + ACC_W'(val);
      2'b01: m_v = m_v - ACC_W'(val);
      2'b10: begin
        tmp = {1'b0, m_v} + (ACC_W+1)'(val);
        m_v = tmp[ACC_W:1];
      end
      default: m_v = '0;
    endcase
  endtask

  // Returns #1 after the start edge; expected result queued at drive time.
  task automatic start_resolve();
    @(negedge clk);
    resolve_start = 1'b1;
    sb.push_back(m_v[WIDTH:0]);
    @(posedge clk);
    #1 resolve_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat, output bit got);
    got = 1'b0; lat = 0;
    for (int n = 1; n <= budget && !got; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin got = 1'b1; lat = n; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b0; op_i = 2'b00; operand = '0; resolve_start = 1'b0;
    m_v = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL reset_op_ready: got %b expected 1", op_ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== '0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (carry_zero !== 1'b1) begin failures++; $display("FAIL reset_carry_zero: got %b expected 1", carry_zero); end
  endtask

  task automatic test_add_basic();
    int lat; bit got; logic [WIDTH:0] exp;
    do_op(2'b00, WIDTH'(3));
    do_op(2'b00, WIDTH'(3));
    checks++; if (carry_zero !== 1'b0) begin failures++; $display("FAIL add_cz_before: got %b expected 0", carry_zero); end
    start_resolve();
    wait_done(30, lat, got);
    exp = sb.pop_front();
    checks++;
    if (!got) begin failures++; $display("FAIL add_timeout: done not seen in 30 cycles"); end
    else begin
      if (lat !== NCHUNK + 1) begin failures++; $display("FAIL add_latency: got %0d expected %0d", lat, NCHUNK + 1); end
      checks++; if (result !== exp) begin failures++; $display("FAIL add_result: got %h expected %h", result, exp); end
      checks++; if (carry_zero !== 1'b1) begin failures++; $display("FAIL add_cz_after: got %b expected 1", carry_zero); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL add_done_pulse: got %b expected 0", done); end
    end
  endtask

  task automatic test_add_shift();
    int lat; bit got; logic [WIDTH:0] exp; logic [WIDTH-1:0] x;
    do_op(2'b11, '0);
    x = '0; x[512] = 1'b1;
    repeat (3) do_op(2'b00, x);
    do_op(2'b00, WIDTH'(6));
    do_op(2'b10, WIDTH'(1));
    start_resolve();
    wait_done(30, lat, got);
    exp = sb.pop_front();
    checks++;
    if (!got) begin failures++; $display("FAIL shift_timeout: done not seen in 30 cycles"); end
    else if (result !== exp) begin failures++; $display("FAIL shift_result: got %h expected %h", result, exp); end
  endtask

  task automatic test_sub();
    int lat; bit got; logic [WIDTH:0] exp;
    do_op(2'b11, '0);
    do_op(2'b00, WIDTH'(5));
    do_op(2'b01, WIDTH'(7));
    start_resolve();
    wait_done(30, lat, got);
    exp = sb.pop_front();
    checks++;
    if (!got) begin failures++; $display("FAIL sub_timeout: done not seen in 30 cycles"); end
    else begin
      if (result !== exp) begin failures++; $display("FAIL sub_result: got %h expected %h", result, exp); end
      checks++; if (carry_zero !== 1'b1) begin failures++; $display("FAIL sub_cz_after: got %b expected 1", carry_zero); end
    end
  endtask

  task automatic test_ripple();
    int lat; bit got; logic [WIDTH:0] exp;
    do_op(2'b11, '0);
    do_op(2'b00, '1);
    do_op(2'b00, WIDTH'(1));
    start_resolve();
    wait_done(30, lat, got);
    exp = sb.pop_front();
    checks++;
    if (!got) begin failures++; $display("FAIL ripple_timeout: done not seen in 30 cycles"); end
    else begin
      if (lat !== NCHUNK + 1) begin failures++; $display("FAIL ripple_latency: got %0d expected %0d", lat, NCHUNK + 1); end
      checks++; if (result !== exp) begin failures++; $display("FAIL ripple_result: got %h expected %h", result, exp); end
    end
  endtask

  task automatic test_op_during_resolve();
    int lat; bit got; logic [WIDTH:0] exp; int bad;
    do_op(2'b11, '0);
    do_op(2'b00, WIDTH'(4));
    do_op(2'b00, WIDTH'(10));
    start_resolve();
    op_valid = 1'b1; op_i = 2'b00; operand = WIDTH'(9);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (op_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    checks++; if (bad != 0) begin failures++; $display("FAIL busy_op_ready: high in %0d cycles expected 0", bad); end
    wait_done(30, lat, got);
    exp = sb.pop_front();
    checks++;
    if (!got) begin failures++; $display("FAIL busy_timeout: done not seen in 30 cycles"); end
    else if (result !== exp) begin failures++; $display("FAIL busy_result: got %h expected %h", result, exp); end
    // Accumulation continues on the resolved value.
    do_op(2'b00, WIDTH'(1));
    start_resolve();
    wait_done(30, lat, got);
    exp = sb.pop_front();
    checks++;
    if (!got) begin failures++; $display("FAIL continue_timeout: done not seen in 30 cycles"); end
    else if (result !== exp) begin failures++; $display("FAIL continue_result: got %h expected %h", result, exp); end
  endtask

  task automatic test_reset_mid_resolve();
    int lat; bit got; bit seen; logic [WIDTH:0] exp;
    do_op(2'b11, '0);
    do_op(2'b00, WIDTH'(100));
    do_op(2'b00, WIDTH'(100));
    start_resolve();
    @(posedge clk); #1 reset = 1'b1;
    #2;
    checks++; if (dut.r_s !== '0) begin failures++; $display("FAIL midrst_s: got %h expected 0", dut.r_s); end
    checks++; if (dut.r_c !== '0) begin failures++; $display("FAIL midrst_c: got %h expected 0", dut.r_c); end
    checks++; if (result !== '0) begin failures++; $display("FAIL midrst_result: got %h expected 0", result); end
    checks++; if (carry_zero !== 1'b1) begin failures++; $display("FAIL midrst_cz: got %b expected 1", carry_zero); end
    sb.delete();
    m_v = '0;
    @(negedge clk) reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL midrst_done: done pulsed after reset, expected none"); end
    checks++; if (op_ready !== 1'b1) begin failures++; $display("FAIL midrst_op_ready: got %b expected 1", op_ready); end
    start_resolve();
    wait_done(30, lat, got);
    exp = sb.pop_front();
    checks++;
    if (!got) begin failures++; $display("FAIL midrst_timeout: done not seen in 30 cycles"); end
    else if (result !== exp) begin failures++; $display("FAIL midrst_result2: got %h expected %h", result, exp); end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_shift();
    test_sub();
    test_ripple();
    test_op_during_resolve();
    test_reset_mid_resolve();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mp_csa_accumulator.md
Name: mp_csa_accumulator

Overview:
Parametrised multi-precision carry-save accumulator for the Montgomery datapath.
- Accepts one operand per cycle: add, subtract, add-then-halve, or clear, each applied in carry-save form with no carry propagation.
- On request, resolves the redundant sum into a binary result with a chunked ripple adder, CHUNK bits per cycle, signalling completion with a done pulse.
- Generalises the single-width adder with configurable width and chunk size, true subtraction, a start/done handshake and in-place resolution.

Parameters:
WIDTH, 514, operand width in bits.
CHUNK, 128, bits resolved per cycle during carry resolution.
ACC_W (localparam), WIDTH+2, internal sum/carry register width.
NCHUNK (localparam), ceil(ACC_W/CHUNK), resolve cycles (5 at defaults).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
op_valid  in  1  apply op this cycle when op_ready=1.
op  in  2  00 ADD, 01 SUB, 10 ADD_SHIFT, 11 CLEAR.
operand  in  WIDTH  unsigned operand.
op_ready  out  1  high in IDLE.
resolve_start  in  1  request carry resolution.
done  out  1  one-cycle pulse, result valid.
result  out  WIDTH+1  resolved value, low WIDTH+1 bits (two's complement).
carry_zero  out  1  registered: carry register and cin both zero.

Behaviour:
- State: S, C (ACC_W each), cin (1 bit). Represented value V = S + C + cin mod 2^ACC_W.
- Reset: S, C, cin = 0; state IDLE; op_ready=1; done=0; result=0; carry_zero=1.
- FSM states: IDLE, RESOLVE, DONE.
  - IDLE -> RESOLVE on resolve_start (or a pending start).
  - RESOLVE stays NCHUNK cycles, chunk index k = 0..NCHUNK-1.
  - RESOLVE -> DONE after the last chunk.
  - DONE -> IDLE unconditionally after 1 cycle.
- ADD: A = zero-extended operand; S' = S^C^A; C' = maj(S,C,A) << 1; cin' = cin.
- SUB: A = ~operand (ACC_W-bit); same CSA; C'[0] = 1 (the +1 injection); cin' = cin.
- ADD_SHIFT: compute the ADD result, then shift right by 1.
  - S'' = S'>>1 and C'' = C'>>1, logical.
  - cin'' = (S'[0] & C'[0]) | (S'[0]^C'[0]) & cin. Equivalently, cin'' = 1 when S'[0] + C'[0] + cin >= 2.
  - Caller guarantees V is even; the odd case truncates.
- CLEAR: S, C, cin = 0.
- op_valid while not IDLE: ignored, no state change.
- op_valid and resolve_start in the same IDLE cycle: op applied; start latched as pending; RESOLVE begins next cycle on the updated state.
- RESOLVE chunk k:
  - {cy, S[k-chunk]} = S_chunk + C_chunk + cy_in; C_chunk = 0.
  - cy_in = cin for k=0, else the registered carry.
  - cin cleared at k=0.
  - Final carry-out discarded (mod 2^ACC_W).
- Latency: resolve_start sampled at edge t; done high in cycle t+NCHUNK+1; result = S[WIDTH:0] registered in the same cycle.
- Result and accumulator state are held until the next op; accumulation may continue after resolve.
- carry_zero updates every cycle from the next-state C and cin.
- Reset asserted mid-RESOLVE: immediate return to reset values; partial resolution discarded.

Optional Feature:
MP_RESULT_WINDOW_EN
- Defined: the result port becomes CHUNK bits wide, plus an input win_sel [$clog2(NCHUNK)-1:0].
  - result = S[win_sel*CHUNK +: CHUNK], registered with 1-cycle latency; out-of-range select gives 0.
  - Intended for narrow bus readout.
- Undefined: full WIDTH+1 result port; no win_sel port.

Decomposition:
- Package mp_pkg:
  - op encoding enum: MP_ADD, MP_SUB, MP_ADD_SHIFT, MP_CLEAR.
  - FSM state enum.
  - ceil-div function for NCHUNK.
- One sub-module: mp_csa_row, a combinational WIDTH-parametrised 3:2 compressor returning sum and shifted carry, instantiated once.
- Chunk adder and FSM stay inline.

Test Plan:
- ADD 3, ADD 3, resolve_start -> done exactly 6 cycles after start edge (NCHUNK+1); result = 6; carry_zero = 1 after done.
- X = 2^512: ADD X three times, ADD 6, ADD_SHIFT 1, resolve -> result = 3*2^511 + 3.
- ADD 5, SUB 7, resolve -> result = 2^515 - 2 (all ones except bit 0, 515-bit field).
- ADD 2^514-1, ADD 1, resolve -> result = 2^514 (only bit 514 set); carry ripples across all 5 chunks.
- op_valid=1 with ADD 9 during RESOLVE -> op_ready = 0, value unchanged, result matches the pre-resolve sum.
- reset pulsed in 2nd RESOLVE cycle -> S, C, result = 0, done never pulses, op_ready = 1 next cycle.
